ram_access_master: RTL and testbench

//  Initiator side of the single-port RAM interface (address/clock/data/wren -> q) used by ramLPM.

---
 rtl/ram_access_master.sv | 134 +++++++++++++
 tb/tb_ram_access_master.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_master.sv
// ram_access_master: initiator for a single-port synchronous RAM
// (address/data/wren -> q). Takes one read/write command at a time over a
// valid/ready handshake, drives the RAM port from registers, captures q after
// RD_LATENCY edges and returns one response per command.
// Optional build macro: CLEAR_ON_RESET_EN -- reset sweeps CLEAR_VALUE into
// every RAM word before the first command is accepted.
module ram_access_master #(
  parameter int                ADDR_W      = 5,
  parameter int                DATA_W      = 8,
  parameter int                RD_LATENCY  = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
`ifdef CLEAR_ON_RESET_EN
    , CLEAR
`endif
  } state_t;

  state_t     state;
  logic       is_wr;   // kind of the command in flight (ram_wren drops after one cycle)
  logic [1:0] cnt;     // remaining edges before q is valid

  // Command sequencer: every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_addr    <= '0;
      rsp_data    <= '0;
      ram_address <= '0;
      is_wr       <= 1'b0;
      cnt         <= '0;
`ifdef CLEAR_ON_RESET_EN
      // Sweep starts at address 0 with the write already on the port.
      state       <= CLEAR;
      cmd_ready   <= 1'b0;
      busy        <= 1'b1;
      ram_wren    <= 1'b1;
      ram_data    <= CLEAR_VALUE;
`else
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      ram_wren    <= 1'b0;
      // CLEAR_VALUE has no effect without the sweep; the data port resets to 0.
      ram_data    <= CLEAR_VALUE & {DATA_W{1'b0}};
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ram_address <= cmd_addr;
            ram_data    <= cmd_data;
            ram_wren    <= cmd_write;
            is_wr       <= cmd_write;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // RAM samples the port on this edge; the write strobe is one cycle.
          ram_wren  <= 1'b0;
          rsp_write <= is_wr;
          rsp_addr  <= ram_address;
          if (is_wr) begin
            rsp_data <= ram_data;
            state    <= RESP;
          end else begin
            cnt   <= 2'(RD_LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            rsp_data  <= ram_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP: begin
          // Writes arrive here with rsp_valid low; reads arrive with it set.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
`ifdef CLEAR_ON_RESET_EN
        CLEAR: begin
          if (&ram_address) begin
            ram_wren  <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            ram_address <= ram_address + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_master.sv
// Directed bench for ram_access_master with a behavioural 32x8 RAM
// (read latency 1, registered q, old data on read).
module tb_ram_access_master;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid, rsp_ready, rsp_write;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  ram_access_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1), .CLEAR_VALUE(8'hEE)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .busy(busy),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  // Behavioural RAM model
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 8'h00;
  always @(posedge clock) begin
    ram_q <= mem[ram_address];
    if (ram_wren) mem[ram_address] <= ram_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full command with rsp_ready held high; returns the response data.
  task automatic do_cmd(input string tag, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] rd);
    int n;
    cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1; rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_addr"}, 32'(rsp_addr), 32'(a));
    chk({tag, "_rsp_write"}, 32'(rsp_write), 32'(wr));
    rd = rsp_data;
    step();
    chk({tag, "_idle"}, 32'(cmd_ready), 32'd1);
  endtask

  logic [DATA_W-1:0] rd;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0;
    step(); step();
    reset = 1'b0;

`ifdef CLEAR_ON_RESET_EN
    // Clear sweep: wren high for 32 cycles walking addresses 0..31
    begin
      int n = 0;
      while (ram_wren && n < 100) begin
        chk("clr_addr", 32'(ram_address), n);
        chk("clr_data", 32'(ram_data), 32'hEE);
        n++;
        step();
      end
      chk("clr_count", n, 32);
    end
    chk("clr_ready", 32'(cmd_ready), 32'd1);
    do_cmd("clr_rd0", 1'b0, 5'd0, 8'h00, rd);  chk("clr_rd0_data", 32'(rd), 32'hEE);
    do_cmd("clr_rd17", 1'b0, 5'd17, 8'h00, rd); chk("clr_rd17_data", 32'(rd), 32'hEE);
    do_cmd("clr_rd31", 1'b0, 5'd31, 8'h00, rd); chk("clr_rd31_data", 32'(rd), 32'hEE);
`else
    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ram_wren", 32'(ram_wren), 32'd0);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
`endif

    // Test 1: write 5 <- A3, step by step
    cmd_write = 1'b1; cmd_addr = 5'd5; cmd_data = 8'hA3; cmd_valid = 1'b1; rsp_ready = 1'b1;
    step();                                   // E0: accept
    cmd_valid = 1'b0;
    chk("t1_wren_e0", 32'(ram_wren), 32'd1);
    chk("t1_addr_e0", 32'(ram_address), 32'd5);
    chk("t1_data_e0", 32'(ram_data), 32'hA3);
    chk("t1_ready_e0", 32'(cmd_ready), 32'd0);
    chk("t1_busy_e0", 32'(busy), 32'd1);
    step();                                   // E1: RAM writes
    chk("t1_wren_e1", 32'(ram_wren), 32'd0);
    step();                                   // E2: response visible
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_write", 32'(rsp_write), 32'd1);
    chk("t1_rsp_data", 32'(rsp_data), 32'hA3);
    chk("t1_rsp_addr", 32'(rsp_addr), 32'd5);
    step();                                   // handshake
    chk("t1_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("t1_ready_back", 32'(cmd_ready), 32'd1);
    chk("t1_busy_back", 32'(busy), 32'd0);

    // Test 2: read 5, response two cycles after accept
    cmd_write = 1'b0; cmd_addr = 5'd5; cmd_valid = 1'b1;
    step();                                   // E0
    cmd_valid = 1'b0;
    chk("t2_wren_e0", 32'(ram_wren), 32'd0);
    chk("t2_addr_e0", 32'(ram_address), 32'd5);
    step();                                   // E1
    chk("t2_rsp_e1", 32'(rsp_valid), 32'd0);
    step();                                   // E2
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rsp_data", 32'(rsp_data), 32'hA3);
    chk("t2_rsp_addr", 32'(rsp_addr), 32'd5);
    chk("t2_rsp_write", 32'(rsp_write), 32'd0);
    step();

    // Test 3: read 5 with rsp_ready low for 4 cycles; second command held
    rsp_ready = 1'b0;
    cmd_write = 1'b0; cmd_addr = 5'd5; cmd_valid = 1'b1;
    step();
    cmd_write = 1'b1; cmd_addr = 5'd3; cmd_data = 8'h55;   // pending second command
    step(); step();
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t3_hold_data", 32'(rsp_data), 32'hA3);
      chk("t3_hold_addr", 32'(rsp_addr), 32'd5);
      chk("t3_hold_ready", 32'(cmd_ready), 32'd0);
      chk("t3_hold_wren", 32'(ram_wren), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();                                   // handshake
    chk("t3_hs_valid", 32'(rsp_valid), 32'd0);
    chk("t3_hs_wren", 32'(ram_wren), 32'd0);
    step();                                   // second command accepted now
    cmd_valid = 1'b0;
    chk("t3_acc_wren", 32'(ram_wren), 32'd1);
    chk("t3_acc_addr", 32'(ram_address), 32'd3);
    step(); step();
    chk("t3_wr_rsp", 32'(rsp_valid), 32'd1);
    chk("t3_wr_data", 32'(rsp_data), 32'h55);
    step();

    // Test 4: boundary addresses
    do_cmd("t4_w31", 1'b1, 5'd31, 8'h7F, rd); chk("t4_w31_data", 32'(rd), 32'h7F);
    do_cmd("t4_w0", 1'b1, 5'd0, 8'h01, rd);   chk("t4_w0_data", 32'(rd), 32'h01);
    do_cmd("t4_r31", 1'b0, 5'd31, 8'h00, rd); chk("t4_r31_data", 32'(rd), 32'h7F);
    do_cmd("t4_r0", 1'b0, 5'd0, 8'h00, rd);   chk("t4_r0_data", 32'(rd), 32'h01);
    do_cmd("t4_r3", 1'b0, 5'd3, 8'h00, rd);   chk("t4_r3_data", 32'(rd), 32'h55);

    // Test 5: reset during ISSUE of a write to 9
    cmd_write = 1'b1; cmd_addr = 5'd9; cmd_data = 8'h42; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("t5_wren_issue", 32'(ram_wren), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
`ifdef CLEAR_ON_RESET_EN
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_clr_addr", 32'(ram_address), 32'd0);
`else
    chk("t5_wren", 32'(ram_wren), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    step(); step(); step();
    chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    chk("t5_no_wren", 32'(ram_wren), 32'd0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
